// File: rtl/dp_cmd_sequencer_if.sv
// Command, response and Datapath-drive signals of dp_cmd_sequencer.
// The sequencer uses the master modport; the command source and the Datapath side use slave.
interface dp_cmd_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_op;
   logic [REG_AW-1:0] cmd_rd;
   logic [REG_AW-1:0] cmd_rn;
   logic [REG_AW-1:0] cmd_rm;
   logic [REG_AW-1:0] cmd_ra;
   logic [DATA_W-1:0] cmd_imm;

   logic [REG_AW-1:0] RA1;
   logic [REG_AW-1:0] RA2;
   logic [REG_AW-1:0] RA3;
   logic [REG_AW-1:0] WA;
   logic [DATA_W-1:0] WD;
   logic              RegWrite;
   logic [2:0]        ALUControl;
   logic              MLA_Select;
   logic [DATA_W-1:0] ALUResult;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_ra, cmd_imm,
      input  ALUResult, rsp_ready,
      output cmd_ready, RA1, RA2, RA3, WA, WD, RegWrite, ALUControl, MLA_Select,
      output rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_ra, cmd_imm,
      output ALUResult, rsp_ready,
      input  cmd_ready, RA1, RA2, RA3, WA, WD, RegWrite, ALUControl, MLA_Select,
      input  rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/dp_cmd_sequencer.sv
// Command-driven initiator for the register-file/ALU Datapath: one command in, one response out.
// Optional DP_SEQ_PERF_CNT_EN adds the retire_cnt output (count of retired responses).
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// EXEC   | read addresses and ALU op driven, waiting WAIT_CYC cycles for the ALU to settle
// WB     | one-cycle register write of the result to rd
// RSP    | response held until rsp_ready
module dp_cmd_sequencer #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 4,
   parameter int WAIT_CYC = 1
) (
   input  logic clk,
   input  logic reset,
   dp_cmd_sequencer_if.master bus
`ifdef DP_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_RSP  = 2'd3;

   localparam logic [3:0] OP_MLA    = 4'b0100;
   localparam logic [3:0] OP_LDI    = 4'b0111;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

   logic [1:0]        r_state;
   logic [3:0]        r_wait;
   logic [REG_AW-1:0] r_rd;
   logic [DATA_W-1:0] r_result;

   logic              r_cmd_ready;
   logic [REG_AW-1:0] r_ra1;
   logic [REG_AW-1:0] r_ra2;
   logic [REG_AW-1:0] r_ra3;
   logic [REG_AW-1:0] r_wa;
   logic [DATA_W-1:0] r_wd;
   logic              r_regwrite;
   logic [2:0]        r_aluctl;
   logic              r_mla;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.RA1        = r_ra1;
   assign bus.RA2        = r_ra2;
   assign bus.RA3        = r_ra3;
   assign bus.WA         = r_wa;
   assign bus.WD         = r_wd;
   assign bus.RegWrite   = r_regwrite;
   assign bus.ALUControl = r_aluctl;
   assign bus.MLA_Select = r_mla;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_err    = r_rsp_err;

   // Every output is set on the edge that enters the state that owns it (Moore, registered).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_rd        <= '0;
         r_result    <= '0;
         r_cmd_ready <= 1'b1;
         r_ra1       <= '0;
         r_ra2       <= '0;
         r_ra3       <= '0;
         r_wa        <= '0;
         r_wd        <= '0;
         r_regwrite  <= 1'b0;
         r_aluctl    <= 3'b000;
         r_mla       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_rd        <= bus.cmd_rd;
                  if (bus.cmd_op[3]) begin
                     r_result    <= '0;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= S_RSP;
                  end else if (bus.cmd_op == OP_LDI) begin
                     r_result   <= bus.cmd_imm;
                     r_wa       <= bus.cmd_rd;
                     r_wd       <= bus.cmd_imm;
                     r_regwrite <= 1'b1;
                     r_state    <= S_WB;
                  end else begin
                     r_ra1    <= bus.cmd_rn;
                     r_ra2    <= bus.cmd_rm;
                     r_ra3    <= bus.cmd_ra;
                     r_aluctl <= bus.cmd_op[2:0];
                     r_mla    <= (bus.cmd_op == OP_MLA);
                     r_wait   <= WAIT_LAST;
                     r_state  <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (r_wait == 4'd0) begin
                  r_result   <= bus.ALUResult;
                  r_ra1      <= '0;
                  r_ra2      <= '0;
                  r_ra3      <= '0;
                  r_aluctl   <= 3'b000;
                  r_mla      <= 1'b0;
                  r_wa       <= r_rd;
                  r_wd       <= bus.ALUResult;
                  r_regwrite <= 1'b1;
                  r_state    <= S_WB;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            S_WB: begin
               r_regwrite  <= 1'b0;
               r_wa        <= '0;
               r_wd        <= '0;
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= r_result;
               r_rsp_err   <= 1'b0;
               r_state     <= S_RSP;
            end
            default: begin
               // Retire edge only reopens cmd_ready, so a new accept happens one edge later.
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

`ifdef DP_SEQ_PERF_CNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retire_cnt <= '0;
      end else if (r_rsp_valid && bus.rsp_ready) begin
         r_retire_cnt <= r_retire_cnt + 32'd1;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_dp_cmd_sequencer.sv
// Bench for dp_cmd_sequencer with a behavioural register file + ALU standing in for the Datapath.
module tb_dp_cmd_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dp_cmd_sequencer_if #(.DATA_W(32), .REG_AW(4)) bus();

`ifdef DP_SEQ_PERF_CNT_EN
   logic [31:0] retire_cnt;
   dp_cmd_sequencer #(.DATA_W(32), .REG_AW(4), .WAIT_CYC(1)) dut (
      .clk(clk), .reset(reset), .bus(bus.master), .retire_cnt(retire_cnt));
`else
   dp_cmd_sequencer #(.DATA_W(32), .REG_AW(4), .WAIT_CYC(1)) dut (
      .clk(clk), .reset(reset), .bus(bus.master));
`endif

   int checks = 0;
   int errors = 0;
   int exp_retired = 0;

   // Datapath stand-in
   logic [31:0] dp_regs [16];
   logic [31:0] dp_a, dp_b, dp_c;
   assign dp_a = dp_regs[bus.RA1];
   assign dp_b = dp_regs[bus.RA2];
   assign dp_c = dp_regs[bus.RA3];

   always @(posedge clk) if (bus.RegWrite) dp_regs[bus.WA] <= bus.WD;

   always_comb begin
      bus.ALUResult = '0;
      case (bus.ALUControl)
         3'b000: bus.ALUResult = dp_a + dp_b;
         3'b001: bus.ALUResult = dp_a - dp_b;
         3'b010: bus.ALUResult = dp_a & dp_b;
         3'b011: bus.ALUResult = dp_a | dp_b;
         3'b100: bus.ALUResult = bus.MLA_Select ? dp_a * dp_b + dp_c : dp_a * dp_b;
         3'b101: if (dp_b != 0) bus.ALUResult = $signed(dp_a) / $signed(dp_b);
         3'b110: if (dp_b != 0) bus.ALUResult = dp_a / dp_b;
         default: bus.ALUResult = '0;
      endcase
   end

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd, rn, rm, ra;
      logic [31:0] imm;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [2:0]  exp_alu;
      logic        exp_mla;
   } vec_t;

   function automatic vec_t mk(logic [3:0] op, logic [3:0] rd, logic [3:0] rn, logic [3:0] rm,
                               logic [3:0] ra, logic [31:0] imm, logic [31:0] d, logic e,
                               int lat, int wr, logic [2:0] alu, logic mla);
      vec_t v;
      v.op = op; v.rd = rd; v.rn = rn; v.rm = rm; v.ra = ra; v.imm = imm;
      v.exp_data = d; v.exp_err = e; v.exp_lat = lat; v.exp_wr = wr;
      v.exp_alu = alu; v.exp_mla = mla;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rn,
                            input logic [3:0] rm, input logic [3:0] ra, input logic [31:0] imm);
      bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rn = rn; bus.cmd_rm = rm;
      bus.cmd_ra = ra; bus.cmd_imm = imm;
   endtask

   task automatic run_cmd(input vec_t v, input int idx);
      int n;
      int wr_cnt;
      logic [3:0]  wa_seen;
      logic [31:0] wd_seen;
      wa_seen = '0; wd_seen = '0; wr_cnt = 0;
      @(negedge clk);
      drive_cmd(v.op, v.rd, v.rn, v.rm, v.ra, v.imm);
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
      check($sformatf("v%0d cmd_ready", idx), {31'b0, bus.cmd_ready}, 32'd1);
      @(negedge clk);
      // accept edge passed; scramble fields to prove they were latched
      bus.cmd_valid = 1'b0;
      drive_cmd(4'hF, 4'hF, 4'hE, 4'hD, 4'hC, 32'hDEAD_BEEF);
      n = 1;
      check($sformatf("v%0d alu", idx), {29'b0, bus.ALUControl}, {29'b0, v.exp_alu});
      check($sformatf("v%0d mla", idx), {31'b0, bus.MLA_Select}, {31'b0, v.exp_mla});
      if (v.exp_lat == 3) begin
         check($sformatf("v%0d ra1", idx), {28'b0, bus.RA1}, {28'b0, v.rn});
         check($sformatf("v%0d ra2", idx), {28'b0, bus.RA2}, {28'b0, v.rm});
         check($sformatf("v%0d ra3", idx), {28'b0, bus.RA3}, {28'b0, v.ra});
      end
      while (!bus.rsp_valid && n < 20) begin
         if (bus.RegWrite) begin wr_cnt++; wa_seen = bus.WA; wd_seen = bus.WD; end
         @(negedge clk);
         n++;
      end
      if (bus.RegWrite) wr_cnt++;
      check($sformatf("v%0d latency", idx), n, v.exp_lat);
      check($sformatf("v%0d rsp_data", idx), bus.rsp_data, v.exp_data);
      check($sformatf("v%0d rsp_err", idx), {31'b0, bus.rsp_err}, {31'b0, v.exp_err});
      check($sformatf("v%0d busy", idx), {31'b0, bus.cmd_ready}, 32'd0);
      check($sformatf("v%0d writes", idx), wr_cnt, v.exp_wr);
      if (v.exp_wr == 1) begin
         check($sformatf("v%0d WA", idx), {28'b0, wa_seen}, {28'b0, v.rd});
         check($sformatf("v%0d WD", idx), wd_seen, v.exp_data);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      exp_retired++;
      check($sformatf("v%0d retired", idx), {31'b0, bus.rsp_valid}, 32'd0);
      check($sformatf("v%0d ready again", idx), {31'b0, bus.cmd_ready}, 32'd1);
`ifdef DP_SEQ_PERF_CNT_EN
      check($sformatf("v%0d retire_cnt", idx), retire_cnt, exp_retired);
`endif
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " cmd_ready"}, {31'b0, bus.cmd_ready}, 32'd1);
      check({tag, " rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
      check({tag, " RegWrite"}, {31'b0, bus.RegWrite}, 32'd0);
      check({tag, " RA"}, {20'b0, bus.RA1, bus.RA2, bus.RA3}, 32'd0);
      check({tag, " ALU"}, {28'b0, bus.ALUControl, bus.MLA_Select}, 32'd0);
      check({tag, " WA/WD"}, bus.WD | {28'b0, bus.WA}, 32'd0);
      check({tag, " rsp_data"}, bus.rsp_data | {31'b0, bus.rsp_err}, 32'd0);
   endtask

   vec_t vecs [14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = mk(4'b0111, 4'd0, 4'd0, 4'd0, 4'd0, 32'd10, 32'd10, 1'b0, 2, 1, 3'b000, 1'b0);
      vecs[1]  = mk(4'b0111, 4'd1, 4'd0, 4'd0, 4'd0, 32'd5,  32'd5,  1'b0, 2, 1, 3'b000, 1'b0);
      vecs[2]  = mk(4'b0111, 4'd2, 4'd0, 4'd0, 4'd0, 32'd2,  32'd2,  1'b0, 2, 1, 3'b000, 1'b0);
      vecs[3]  = mk(4'b0000, 4'd3, 4'd0, 4'd1, 4'd0, 32'd0,  32'd15, 1'b0, 3, 1, 3'b000, 1'b0);
      vecs[4]  = mk(4'b0100, 4'd4, 4'd0, 4'd1, 4'd2, 32'd0,  32'd52, 1'b0, 3, 1, 3'b100, 1'b1);
      vecs[5]  = mk(4'b0101, 4'd5, 4'd0, 4'd1, 4'd0, 32'd0,  32'd2,  1'b0, 3, 1, 3'b101, 1'b0);
      vecs[6]  = mk(4'b0110, 4'd5, 4'd0, 4'd1, 4'd0, 32'd0,  32'd2,  1'b0, 3, 1, 3'b110, 1'b0);
      vecs[7]  = mk(4'b0001, 4'd6, 4'd0, 4'd1, 4'd0, 32'd0,  32'd5,  1'b0, 3, 1, 3'b001, 1'b0);
      vecs[8]  = mk(4'b0010, 4'd7, 4'd0, 4'd1, 4'd0, 32'd0,  32'd0,  1'b0, 3, 1, 3'b010, 1'b0);
      vecs[9]  = mk(4'b0011, 4'd8, 4'd0, 4'd1, 4'd0, 32'd0,  32'd15, 1'b0, 3, 1, 3'b011, 1'b0);
      vecs[10] = mk(4'b1111, 4'd9, 4'd0, 4'd1, 4'd0, 32'd77, 32'd0,  1'b1, 1, 0, 3'b000, 1'b0);
      vecs[11] = mk(4'b0111, 4'd9, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 1'b0, 2, 1, 3'b000, 1'b0);
      vecs[12] = mk(4'b0101, 4'd10, 4'd9, 4'd1, 4'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, 3, 1, 3'b101, 1'b0);
      vecs[13] = mk(4'b0110, 4'd10, 4'd9, 4'd1, 4'd0, 32'd0, 32'h3333_332F, 1'b0, 3, 1, 3'b110, 1'b0);

      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      drive_cmd(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
      #1;
      check_idle_outputs("reset");
`ifdef DP_SEQ_PERF_CNT_EN
      check("reset retire_cnt", retire_cnt, 32'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) run_cmd(vecs[i], i);
      check("r3 after ADD", dp_regs[3], 32'd15);
      check("r4 after MLA", dp_regs[4], 32'd52);

      // Response backpressure with a second command waiting
      @(negedge clk);
      drive_cmd(4'b0000, 4'd11, 4'd0, 4'd1, 4'd0, 32'd0);
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      drive_cmd(4'b0111, 4'd12, 4'd0, 4'd0, 4'd0, 32'd99);
      n = 1;
      while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("hold latency", n, 3);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold%0d rsp_valid", k), {31'b0, bus.rsp_valid}, 32'd1);
         check($sformatf("hold%0d rsp_data", k), bus.rsp_data, 32'd15);
         check($sformatf("hold%0d cmd_ready", k), {31'b0, bus.cmd_ready}, 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      exp_retired++;
      check("retire rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("retire cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("no accept at retire", {31'b0, bus.RegWrite}, 32'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("second accepted WE", {31'b0, bus.RegWrite}, 32'd1);
      check("second accepted WA", {28'b0, bus.WA}, 32'd12);
      check("second accepted WD", bus.WD, 32'd99);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("second rsp_data", bus.rsp_data, 32'd99);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      exp_retired++;
      check("r11 written", dp_regs[11], 32'd15);
`ifdef DP_SEQ_PERF_CNT_EN
      check("hold retire_cnt", retire_cnt, exp_retired);
`endif

      // Reset during EXEC of an ADD targeting r3
      @(negedge clk);
      drive_cmd(4'b0000, 4'd3, 4'd0, 4'd2, 4'd0, 32'd0);
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("pre-reset EXEC RA2", {28'b0, bus.RA2}, 32'd2);
      reset = 1'b1;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("post-reset%0d RegWrite", k), {31'b0, bus.RegWrite}, 32'd0);
         @(negedge clk);
      end
      check("r3 unchanged", dp_regs[3], 32'd15);
      exp_retired = 0;
`ifdef DP_SEQ_PERF_CNT_EN
      check("retire_cnt after reset", retire_cnt, 32'd0);
`endif
      run_cmd(mk(4'b0111, 4'd13, 4'd0, 4'd0, 4'd0, 32'd7, 32'd7, 1'b0, 2, 1, 3'b000, 1'b0), 99);
      check("r13 written", dp_regs[13], 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
